// File: rtl/mdu_iter_core.sv
// Iterative RV32M/RV64M multiply/divide unit: pipelined multiplier, restoring divider, one op in flight.
// Optional MDU_FLUSH_EN adds i_mdu_flush to abandon the current operation.
//
// state | meaning
// IDLE  | ready for a request
// MUL   | product travelling down the multiplier pipe
// DIV   | restoring-division iterations, DIV_BITS quotient bits per cycle
// FIX   | apply result signs to quotient/remainder
// DONE  | result valid, held until consumed
module mdu_iter_core #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_mdu_rs1,
  input  logic [WIDTH-1:0] i_mdu_rs2,
  input  logic [2:0]       i_mdu_op,
  input  logic             i_mdu_valid,
  output logic             o_mdu_ready,
  output logic [WIDTH-1:0] o_mdu_rd,
  output logic             o_mdu_rd_valid,
  input  logic             i_mdu_rd_ready
`ifdef MDU_FLUSH_EN
  ,
  input  logic             i_mdu_flush
`endif
);

  localparam int ITERS = WIDTH / DIV_BITS;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ready_q, rd_valid_q;
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             quo_neg, rem_neg, op_rem;

  logic flush;
`ifdef MDU_FLUSH_EN
  assign flush = i_mdu_flush;
`else
  assign flush = 1'b0;
`endif

  logic accept;
  assign accept = (state == S_IDLE) && i_mdu_valid && !flush;

  // Multiplier: sign-extend straight to 2*WIDTH so the low 2*WIDTH product bits are exact.
  logic               a_signed, b_signed;
  logic [2*WIDTH-1:0] a_x, b_x, prod;
  logic [WIDTH-1:0]   mul_res, mul_tail;

  assign a_signed = (i_mdu_op[1:0] != 2'b11);
  assign b_signed = !i_mdu_op[1];
  assign a_x      = {{WIDTH{a_signed & i_mdu_rs1[WIDTH-1]}}, i_mdu_rs1};
  assign b_x      = {{WIDTH{b_signed & i_mdu_rs2[WIDTH-1]}}, i_mdu_rs2};
  assign prod     = a_x * b_x;
  assign mul_res  = (i_mdu_op[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];

  generate
    if (MUL_STAGES > 1) begin : g_mul_pipe
      logic [WIDTH-1:0] pipe [MUL_STAGES-1];
      always_ff @(posedge i_clk) begin
        if (accept) pipe[0] <= mul_res;
        for (int i = 1; i < MUL_STAGES - 1; i++) pipe[i] <= pipe[i-1];
      end
      assign mul_tail = pipe[MUL_STAGES-2];
    end else begin : g_mul_direct
      assign mul_tail = mul_res;
    end
  endgenerate

  // Divider request decode and special cases.
  logic             signed_div, div_zero, div_ovf, div_special;
  logic [WIDTH-1:0] special_res, abs_a, abs_b;

  assign signed_div  = !i_mdu_op[0];
  assign div_zero    = (i_mdu_rs2 == '0);
  assign div_ovf     = signed_div && (i_mdu_rs1 == MOST_NEG) && (i_mdu_rs2 == '1);
  assign div_special = div_zero || div_ovf;
  assign special_res = div_zero ? (i_mdu_op[1] ? i_mdu_rs1 : '1)
                                : (i_mdu_op[1] ? '0 : i_mdu_rs1);
  assign abs_a = (signed_div && i_mdu_rs1[WIDTH-1]) ? -i_mdu_rs1 : i_mdu_rs1;
  assign abs_b = (signed_div && i_mdu_rs2[WIDTH-1]) ? -i_mdu_rs2 : i_mdu_rs2;

  // One cycle of restoring division; quo_q shifts the dividend out and the quotient in.
  logic [WIDTH-1:0] r_nx, q_nx;
  logic [WIDTH:0]   sh, trial;

  always_comb begin
    r_nx  = rem_q;
    q_nx  = quo_q;
    sh    = '0;
    trial = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      sh    = {r_nx, q_nx[WIDTH-1]};
      trial = sh - {1'b0, dvs_q};
      q_nx  = {q_nx[WIDTH-2:0], !trial[WIDTH]};
      r_nx  = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ready_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      quo_neg    <= 1'b0;
      rem_neg    <= 1'b0;
      op_rem     <= 1'b0;
    end else if (flush && state != S_IDLE) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ready_q    <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (!i_mdu_op[2]) begin
              if (MUL_STAGES == 1) begin
                rd_q       <= mul_res;
                rd_valid_q <= 1'b1;
                state      <= S_DONE;
              end else begin
                cnt   <= CNT_W'(MUL_STAGES - 1);
                state <= S_MUL;
              end
            end else if (div_special) begin
              rd_q       <= special_res;
              rd_valid_q <= 1'b1;
              state      <= S_DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= abs_a;
              dvs_q   <= abs_b;
              quo_neg <= signed_div && (i_mdu_rs1[WIDTH-1] ^ i_mdu_rs2[WIDTH-1]);
              rem_neg <= signed_div && i_mdu_rs1[WIDTH-1];
              op_rem  <= i_mdu_op[1];
              cnt     <= CNT_W'(ITERS);
              state   <= S_DIV;
            end
          end
        end
        S_MUL: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            rd_q       <= mul_tail;
            rd_valid_q <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DIV: begin
          rem_q <= r_nx;
          quo_q <= q_nx;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_FIX;
        end
        S_FIX: begin
          if (op_rem) rd_q <= rem_neg ? -rem_q : rem_q;
          else        rd_q <= quo_neg ? -quo_q : quo_q;
          rd_valid_q <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (i_mdu_rd_ready) begin
            rd_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_mdu_ready    = ready_q;
  assign o_mdu_rd_valid = rd_valid_q;
  assign o_mdu_rd       = rd_q;

endmodule
